// File: rtl/if_chain_pkg.sv
// Shared types for the if/else-if/else chain resolver: evaluation modes and the
// per-transaction verdict carried through the output skid buffer.
package if_chain_pkg;

  typedef enum logic [1:0] {
    MODE_PLAIN    = 2'd0,
    MODE_UNIQUE   = 2'd1,
    MODE_PRIORITY = 2'd2
  } mode_e;

  // Verdict idx is sized for the widest supported chain; users slice it down.
  localparam int IDX_MAX_W = 8;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 none;
    logic                 viol_u;
    logic                 viol_p;
  } verdict_t;

  function automatic int IDX_W(input int n_br);
    return $clog2(n_br + 1);
  endfunction

endpackage

// File: rtl/if_chain_skid.sv
// Two-entry valid/ready buffer of verdicts. in_ready is a registered "not full"
// flag so nothing upstream sees a combinational path from out_ready.
module if_chain_skid
  import if_chain_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  verdict_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output verdict_t out_data
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;
  logic       room_reg;
  logic       push;
  logic       pop;

  assign in_ready  = room_reg;
  assign out_valid = (cnt_reg != 2'd0);
  assign push      = in_valid && room_reg;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cnt_next = cnt_reg;
    if (push && !pop) begin
      cnt_next = cnt_reg + 2'd1;
    end else if (!push && pop) begin
      cnt_next = cnt_reg - 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      verdict_t entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= in_data;
        end
      end
    end
  endgenerate

  assign out_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      room_reg   <= 1'b1;
    end else begin
      cnt_reg  <= cnt_next;
      room_reg <= (cnt_next != 2'd2);
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

endmodule

// File: rtl/if_chain_select.sv
// Resolves one if/else-if/else chain per transaction (PLAIN/UNIQUE/PRIORITY),
// two-cycle pipeline into a skid buffer, plus saturating violation statistics.
module if_chain_select
  import if_chain_pkg::*;
#(
  parameter int N_BR  = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_BR-1:0]         in_cond,
  input  logic [1:0]              in_mode,
  input  logic                    in_has_else,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W(N_BR)-1:0]  out_idx,
  output logic                    out_none,
  output logic                    out_viol_u,
  output logic                    out_viol_p,
  input  logic                    clr_stat,
  output logic [1:0]              stat_sticky,
  output logic [CNT_W-1:0]        cnt_u,
  output logic [CNT_W-1:0]        cnt_p
);

  localparam int IW = IDX_W(N_BR);

  logic          s1_valid_reg;
  logic [IW-1:0] s1_idx_reg;
  logic          s1_onehot_reg;
  logic          s1_zero_reg;
  logic [1:0]    s1_mode_reg;
  logic          s1_has_else_reg;

  logic [IW-1:0] low_idx;
  logic          cond_le1;
  logic          accept;
  logic          skid_in_ready;
  logic          s1_adv;
  verdict_t      verdict;
  verdict_t      skid_out;
  logic          pop;

  logic [CNT_W-1:0] cnt_u_reg;
  logic [CNT_W-1:0] cnt_p_reg;
  logic [1:0]       sticky_reg;

  // Decode: scan from the last arm down so the first `if` wins.
  always_comb begin
    low_idx = '0;
    for (int i = N_BR - 1; i >= 0; i--) begin
      if (in_cond[i]) begin
        low_idx = IW'(i);
      end
    end
  end

  assign cond_le1 = ((in_cond & (in_cond - N_BR'(1))) == '0);

  assign in_ready = skid_in_ready;
  assign accept   = in_valid && skid_in_ready;
  // Stage 1 only ever holds when the skid is full, in which case in_ready is low.
  assign s1_adv   = s1_valid_reg && skid_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_idx_reg      <= '0;
      s1_onehot_reg   <= 1'b0;
      s1_zero_reg     <= 1'b0;
      s1_mode_reg     <= 2'd0;
      s1_has_else_reg <= 1'b0;
    end else if (accept) begin
      s1_valid_reg    <= 1'b1;
      s1_idx_reg      <= low_idx;
      s1_onehot_reg   <= cond_le1 && (|in_cond);
      s1_zero_reg     <= ~(|in_cond);
      s1_mode_reg     <= in_mode;
      s1_has_else_reg <= in_has_else;
    end else if (s1_adv) begin
      s1_valid_reg    <= 1'b0;
    end
  end

  always_comb begin
    verdict      = '0;
    verdict.idx  = s1_zero_reg ? IDX_MAX_W'(N_BR) : IDX_MAX_W'(s1_idx_reg);
    verdict.none = s1_zero_reg && !s1_has_else_reg;
    case (s1_mode_reg)
      MODE_UNIQUE:   verdict.viol_u = verdict.none || (!s1_zero_reg && !s1_onehot_reg);
      MODE_PRIORITY: verdict.viol_p = verdict.none;
      default:       ;
    endcase
  end

  if_chain_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_reg),
    .in_ready  (skid_in_ready),
    .in_data   (verdict),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out)
  );

  logic unused_idx_bits;
  assign unused_idx_bits = ^skid_out.idx;

  assign out_idx    = skid_out.idx[IW-1:0];
  assign out_none   = skid_out.none;
  assign out_viol_u = skid_out.viol_u;
  assign out_viol_p = skid_out.viol_p;
  assign pop        = out_valid && out_ready;

  // Statistics count delivered results only; a same-cycle clear takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_u_reg  <= '0;
      cnt_p_reg  <= '0;
      sticky_reg <= 2'b00;
    end else if (clr_stat) begin
      cnt_u_reg  <= '0;
      cnt_p_reg  <= '0;
      sticky_reg <= 2'b00;
    end else if (pop) begin
      if (skid_out.viol_u) begin
        sticky_reg[0] <= 1'b1;
        if (cnt_u_reg != '1) begin
          cnt_u_reg <= cnt_u_reg + CNT_W'(1);
        end
      end
      if (skid_out.viol_p) begin
        sticky_reg[1] <= 1'b1;
        if (cnt_p_reg != '1) begin
          cnt_p_reg <= cnt_p_reg + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_u       = cnt_u_reg;
  assign cnt_p       = cnt_p_reg;
  assign stat_sticky = sticky_reg;

endmodule

// File: tb/tb_if_chain_select.sv
// Directed vectors and handshake sequences for if_chain_select (N_BR=8 main,
// plus a CNT_W=2 copy for saturation and an N_BR=1 copy for the degenerate chain).
module tb_if_chain_select;
  import if_chain_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, out_ready, in_has_else, clr_stat;
  logic [7:0] in_cond;
  logic [1:0] in_mode;

  logic        in_ready, out_valid, out_none, out_viol_u, out_viol_p;
  logic [3:0]  out_idx;
  logic [1:0]  stat_sticky;
  logic [15:0] cnt_u, cnt_p;

  logic        s_in_ready, s_out_valid, s_none, s_vu, s_vp;
  logic [3:0]  s_idx;
  logic [1:0]  s_sticky, s_cnt_u, s_cnt_p;

  logic        o_in_ready, o_out_valid, o_none, o_vu, o_vp;
  logic [0:0]  o_idx;
  logic [1:0]  o_sticky;
  logic [15:0] o_cnt_u, o_cnt_p;

  if_chain_select #(.N_BR(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
    .in_mode(in_mode), .in_has_else(in_has_else), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_none(out_none), .out_viol_u(out_viol_u), .out_viol_p(out_viol_p),
    .clr_stat(clr_stat), .stat_sticky(stat_sticky), .cnt_u(cnt_u), .cnt_p(cnt_p)
  );

  if_chain_select #(.N_BR(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_cond(in_cond),
    .in_mode(in_mode), .in_has_else(in_has_else), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_idx(s_idx), .out_none(s_none), .out_viol_u(s_vu), .out_viol_p(s_vp),
    .clr_stat(clr_stat), .stat_sticky(s_sticky), .cnt_u(s_cnt_u), .cnt_p(s_cnt_p)
  );

  if_chain_select #(.N_BR(1), .CNT_W(16)) dut_one (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready), .in_cond(in_cond[0:0]),
    .in_mode(in_mode), .in_has_else(in_has_else), .out_valid(o_out_valid), .out_ready(out_ready),
    .out_idx(o_idx), .out_none(o_none), .out_viol_u(o_vu), .out_viol_p(o_vp),
    .clr_stat(clr_stat), .stat_sticky(o_sticky), .cnt_u(o_cnt_u), .cnt_p(o_cnt_p)
  );

  typedef struct {
    logic [7:0] cond;
    logic [1:0] mode;
    logic       he;
    logic [3:0] idx;
    logic       none;
    logic       vu;
    logic       vp;
  } vec_t;

  vec_t vecs[12];

  int total = 0;
  int bad   = 0;

  logic [3:0] g_idx;
  logic       g_none, g_vu, g_vp;
  logic [0:0] g_o_idx;
  logic       g_o_none, g_o_vu, g_o_vp;
  int         g_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction; records the result and its in->out latency in edges.
  task automatic txn(input logic [7:0] c, input logic [1:0] m, input logic he, input logic clr);
    int n;
    in_cond = c; in_mode = m; in_has_else = he; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    g_lat = n + 1;
    g_idx = out_idx; g_none = out_none; g_vu = out_viol_u; g_vp = out_viol_p;
    g_o_idx = o_idx; g_o_none = o_none; g_o_vu = o_vu; g_o_vp = o_vp;
    clr_stat = clr;
    tick();
    clr_stat = 1'b0;
    $display("txn cond=%b mode=%0d else=%0b -> idx=%0d none=%0b vu=%0b vp=%0b lat=%0d",
             c, m, he, g_idx, g_none, g_vu, g_vp, g_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_cu, exp_cp;
    logic [1:0]  exp_st;
    logic        m_none;
    int          j, first_low, n, stale;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_cond = '0; in_mode = '0;
    in_has_else = 1'b0; clr_stat = 1'b0;

    vecs[0]  = '{8'b0000_0110, 2'd2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'b0001_0100, 2'd1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{8'b0000_0000, 2'd1, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'b0000_0000, 2'd1, 1'b0, 4'd8, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8'b0000_0000, 2'd2, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{8'b0000_0000, 2'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'b1111_1111, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'b1000_0000, 2'd1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'b0000_0000, 2'd3, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'b1000_0001, 2'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'b0100_0000, 2'd1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'b1100_0000, 2'd1, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0};

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_none", out_none, 0);
    chk("rst_viol", {out_viol_u, out_viol_p}, 0);
    chk("rst_sticky", stat_sticky, 0);
    chk("rst_cnt_u", cnt_u, 0);
    chk("rst_cnt_p", cnt_p, 0);
    rst = 1'b0;
    tick();

    exp_cu = 0; exp_cp = 0; exp_st = 2'b00;
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].cond, vecs[i].mode, vecs[i].he, 1'b0);
      chk("vec_latency", g_lat, 2);
      chk("vec_idx", g_idx, vecs[i].idx);
      chk("vec_none", g_none, vecs[i].none);
      chk("vec_viol_u", g_vu, vecs[i].vu);
      chk("vec_viol_p", g_vp, vecs[i].vp);
      if (vecs[i].vu) begin exp_cu++; exp_st[0] = 1'b1; end
      if (vecs[i].vp) begin exp_cp++; exp_st[1] = 1'b1; end
      chk("vec_cnt_u", cnt_u, exp_cu);
      chk("vec_cnt_p", cnt_p, exp_cp);
      chk("vec_sticky", stat_sticky, exp_st);
      // Single-arm chain: arm 0 or the else/fall-through slot at index 1.
      m_none = !vecs[i].cond[0] && !vecs[i].he;
      chk("one_idx", g_o_idx, vecs[i].cond[0] ? 0 : 1);
      chk("one_none", g_o_none, m_none);
      chk("one_viol_u", g_o_vu, (vecs[i].mode == 2'd1) && m_none);
      chk("one_viol_p", g_o_vp, (vecs[i].mode == 2'd2) && m_none);
    end

    // 20 back-to-back transactions against a 1-0-0-1 out_ready pattern.
    begin : b2b
      int k;
      int cyc;
      k = 0;
      fork
        begin
          for (int i = 0; i < 20; i++) begin
            logic acc;
            int   w;
            in_cond = (i % 9 == 8) ? 8'h00 : 8'(1 << (i % 9));
            in_mode = 2'd0; in_has_else = 1'b1; in_valid = 1'b1;
            acc = 1'b0; w = 0;
            while (!acc && w < 100) begin acc = in_ready; tick(); w++; end
          end
          in_valid = 1'b0;
        end
        begin
          cyc = 0;
          while (k < 20 && cyc < 400) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (out_valid && out_ready) begin
              $display("b2b out #%0d idx=%0d", k, out_idx);
              chk("b2b_idx", out_idx, k % 9);
              k++;
            end
            tick();
            cyc++;
          end
        end
      join
      out_ready = 1'b1;
      chk("b2b_count", k, 20);
      tick(); tick();
      chk("b2b_no_extra", out_valid, 0);
    end

    // Hold out_ready low: stage 1 + two skid entries fill, then in_ready drops.
    out_ready = 1'b0; j = 0; first_low = -1;
    in_valid = 1'b1; in_mode = 2'd0; in_has_else = 1'b1; in_cond = 8'h01;
    for (int c = 0; c < 8; c++) begin
      if (in_ready) begin
        tick(); j++; in_cond = 8'(1 << j);
      end else begin
        if (first_low < 0) first_low = c;
        tick();
      end
    end
    in_valid = 1'b0;
    $display("backpressure accepted=%0d first_low_cycle=%0d", j, first_low);
    chk("bp_accepted", j, 3);
    chk("bp_first_low", first_low, 3);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      $display("drain out #%0d idx=%0d", k, out_idx);
      chk("bp_drain_idx", out_idx, k);
      tick();
    end
    chk("bp_drained", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);

    // Queue two results, then pulse reset between clock edges.
    out_ready = 1'b0; in_valid = 1'b1; in_cond = 8'h10; in_mode = 2'd1; in_has_else = 1'b0;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("rstq_queued", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    $display("reset pulse: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    chk("rstq_async_drop", out_valid, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1; stale = 0;
    repeat (6) begin
      tick();
      if (out_valid) stale++;
    end
    chk("rstq_stale", stale, 0);
    chk("rstq_in_ready", in_ready, 1);
    chk("rstq_cnt_u", cnt_u, 0);

    // Saturation on the CNT_W=2 copy, then clear racing a 6th violation.
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      txn(8'h00, 2'd2, 1'b0, 1'b0);
      $display("sat step %0d cnt_p(2b)=%0d cnt_p(16b)=%0d", k, s_cnt_p, cnt_p);
      chk("sat_cnt_p", s_cnt_p, (k > 3) ? 3 : k);
    end
    chk("sat_wide_cnt_p", cnt_p, 5);
    chk("sat_sticky", s_sticky, 2'b10);
    txn(8'h00, 2'd2, 1'b0, 1'b1);
    chk("clr_vs_inc_sat", s_cnt_p, 0);
    chk("clr_vs_inc_wide", cnt_p, 0);
    chk("clr_sticky", stat_sticky, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
